// File: rtl/router_pkg.sv
// Shared types and header field positions for the router egress path.
package router_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_e;

  localparam int ADDR_LSB    = 0;
  localparam int ADDR_MSB    = 1;
  localparam int LEN_LSB     = 2;
  localparam int LEN_MSB     = 7;
  localparam int TIMEOUT_DEF = 30;

endpackage

// File: rtl/router_rr_pick.sv
// Combinational round-robin picker: first requester after last_grant,
// wrapping modulo NUM_PORTS.
module router_rr_pick #(
  parameter int NUM_PORTS = 3,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     last_grant,
  output logic [IDX_W-1:0]     idx,
  output logic                 any
);

  logic [IDX_W-1:0] cand;

  // Walk farthest-first so the nearest requester is written last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      cand = IDX_W'((int'(last_grant) + i) % NUM_PORTS);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arb.sv
// Packet-granular round-robin drain of router FIFOs onto one egress port.
// ROUTER_ARB_PARITY_CHK_EN adds a running-XOR parity check (parity_err).
module router_out_arb
  import router_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT   = TIMEOUT_DEF,
  parameter int CNT_W     = 6
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        fifo_empty,
  input  logic [NUM_PORTS*DATA_W-1:0] fifo_data,
  output logic [NUM_PORTS-1:0]        read_enb,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [1:0]                  grant,
  output logic                        busy,
  output logic [NUM_PORTS-1:0]        soft_reset
`ifdef ROUTER_ARB_PARITY_CHK_EN
  ,
  output logic                        parity_err
`endif
);

  // One extra bit so a 63-byte payload plus parity fits.
  localparam int REM_W = CNT_W + 1;

  state_e           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_q, last_d;
  logic [REM_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] wdog_q, wdog_d;
  logic [DATA_W-1:0] head;
  logic [1:0]       pick_idx;
  logic             pick_any;

  router_rr_pick #(
    .NUM_PORTS(NUM_PORTS),
    .IDX_W    (2)
  ) u_pick (
    .req       (~fifo_empty),
    .last_grant(last_q),
    .idx       (pick_idx),
    .any       (pick_any)
  );

  always_comb begin
    head = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == 2'(i)) head = fifo_data[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    rem_d      = rem_q;
    wdog_d     = wdog_q;
    out_valid  = 1'b0;
    read_enb   = '0;
    soft_reset = '0;
    out_data   = head;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        out_valid = ~fifo_empty[grant_q];
        if (out_valid && out_ready) begin
          read_enb[grant_q] = 1'b1;
          wdog_d = '0;
          if (rem_q == '0) begin
            rem_d = REM_W'(head[LEN_MSB:LEN_LSB]) + REM_W'(1);
          end else if (rem_q == REM_W'(1)) begin
            rem_d   = '0;
            state_d = DONE;
          end else begin
            rem_d = rem_q - REM_W'(1);
          end
        end else if (out_valid) begin
          if (wdog_q == CNT_W'(TIMEOUT - 1)) begin
            soft_reset[grant_q] = 1'b1;
            state_d = IDLE;
            last_d  = grant_q;
            wdog_d  = '0;
            rem_d   = '0;
          end else begin
            wdog_d = wdog_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Reset mid-packet must not pop or pulse the FIFO.
    if (reset) begin
      out_valid  = 1'b0;
      read_enb   = '0;
      soft_reset = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= 2'(NUM_PORTS - 1);
      rem_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      wdog_q  <= wdog_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q == SEND) || (state_q == DONE);

`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic [DATA_W-1:0] xor_q, xor_d;
  logic              parity_err_q, parity_err_d;
  logic              xfer;

  assign xfer = out_valid & out_ready;

  always_comb begin
    xor_d        = xor_q;
    parity_err_d = 1'b0;
    if (state_q == IDLE) begin
      xor_d = '0;
    end else if (state_q == SEND && xfer) begin
      if (rem_q == REM_W'(1)) parity_err_d = (xor_q != head);
      else                    xor_d = xor_q ^ head;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xor_q        <= '0;
      parity_err_q <= 1'b0;
    end else begin
      xor_q        <= xor_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_router_out_arb.sv
// Self-checking bench for router_out_arb: vector table, corner sequences,
// and a randomized run against a packet-level reference model.
module tb_router_out_arb;

  localparam int NP = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  fifo_empty;
  logic [23:0] fifo_data;
  logic [2:0]  read_enb;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  grant;
  logic        busy;
  logic [2:0]  soft_reset;
`ifdef ROUTER_ARB_PARITY_CHK_EN
  logic        parity_err;
`endif

  always #5 clock = ~clock;

  router_out_arb dut (
    .clock     (clock),
    .reset     (reset),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .read_enb  (read_enb),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .grant     (grant),
    .busy      (busy),
    .soft_reset(soft_reset)
`ifdef ROUTER_ARB_PARITY_CHK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] q   [NP][$];
  logic [7:0] src [NP][$];
  logic [7:0] expq[NP][$];
  logic [7:0] pkt [$];
  logic [7:0] rx  [$];
  logic [1:0] rxg [$];
  int         rxc [$];

  logic       s_valid, s_ready, s_busy, s_perr;
  logic [7:0] s_data;
  logic [2:0] s_rd, s_soft;
  logic [1:0] s_grant;
  int         s_cyc;

  typedef struct {
    int         port;
    int         len;
    int         exp_xfers;
    int         exp_busy;
    logic [2:0] exp_rd;
    int         exp_lat;
  } vec_t;

  vec_t vt[5];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < NP; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_data[i*8 +: 8] = (q[i].size() != 0) ? q[i][0] : 8'hA5;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    s_valid = out_valid;
    s_ready = out_ready;
    s_data  = out_data;
    s_rd    = read_enb;
    s_soft  = soft_reset;
    s_busy  = busy;
    s_grant = grant;
    s_cyc   = cyc;
`ifdef ROUTER_ARB_PARITY_CHK_EN
    s_perr  = parity_err;
`else
    s_perr  = 1'b0;
`endif
    if (s_valid && s_ready) begin
      rx.push_back(s_data);
      rxg.push_back(s_grant);
      rxc.push_back(s_cyc);
    end
    @(posedge clock);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (s_rd[i] && q[i].size() != 0) void'(q[i].pop_front());
      if (s_soft[i]) q[i].delete();
    end
    drive_fifos();
  endtask

  task automatic build_pkt(input int addr, input int len, input bit bad);
    logic [7:0] b, x;
    pkt.delete();
    b = 8'((len << 2) | addr);
    pkt.push_back(b);
    x = b;
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      pkt.push_back(b);
      x ^= b;
    end
    pkt.push_back(bad ? (x ^ 8'h01) : x);
  endtask

  task automatic push_pkt(input int port);
    foreach (pkt[i]) q[port].push_back(pkt[i]);
    drive_fifos();
  endtask

  task automatic clr_rx();
    rx.delete();
    rxg.delete();
    rxc.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) q[i].delete();
    drive_fifos();
    tick();
    tick();
    clr_rx();
    reset = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int b = 0;
    while (rx.size() < n && b < budget) begin
      tick();
      b++;
    end
    check("wait_rx", 32'(rx.size() >= n), 1);
  endtask

  function automatic int rx_diff();
    int d = 0;
    if (rx.size() != pkt.size()) return 999;
    foreach (pkt[i]) if (rx[i] !== pkt[i]) d++;
    return d;
  endfunction

  function automatic int rr(input logic [2:0] ne, input int last);
    int p;
    for (int k = 1; k <= NP; k++) begin
      p = (last + k) % NP;
      if (ne[p[1:0]]) return p;
    end
    return -1;
  endfunction

  function automatic int remaining();
    int n = 0;
    for (int i = 0; i < NP; i++) n += expq[i].size();
    return n;
  endfunction

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int first, nb, nx, gbad, rel, np, pt, stl;
    logic [2:0] rdm, soft_acc;
    int cur_left, cur_port, last_port, last_end, lowrun, exp_g;
    bit in_hdr;
    logic [2:0] ne, prev_ne;
    logic [7:0] exp_b;
    logic perr_acc;

    vt[0] = '{1, 4, 6, 7, 3'b010, 2};
    vt[1] = '{0, 0, 2, 3, 3'b001, 2};
    vt[2] = '{2, 63, 65, 66, 3'b100, 2};
    vt[3] = '{2, 1, 3, 4, 3'b100, 2};
    vt[4] = '{0, 2, 4, 5, 3'b001, 2};

    reset = 1'b1;
    out_ready = 1'b1;
    drive_fifos();
    do_reset();
    check("rst_valid", 32'(s_valid), 0);
    check("rst_rd", 32'(s_rd), 0);
    check("rst_soft", 32'(s_soft), 0);
    check("rst_busy", 32'(s_busy), 0);
    check("rst_grant", 32'(s_grant), 0);
    check("rst_perr", 32'(s_perr), 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      build_pkt(vt[v].port, vt[v].len, 1'b0);
      push_pkt(vt[v].port);
      first = -1;
      nb = 0;
      nx = 0;
      gbad = 0;
      rdm = '0;
      for (int t = 1; t <= 80; t++) begin
        tick();
        if (s_valid && first < 0) first = t;
        if (s_busy) nb++;
        if (s_valid && s_ready) begin
          nx++;
          if (s_grant != 2'(vt[v].port)) gbad++;
        end
        rdm |= s_rd;
      end
      check($sformatf("v%0d_xfers", v), 32'(nx), 32'(vt[v].exp_xfers));
      check($sformatf("v%0d_busy", v), 32'(nb), 32'(vt[v].exp_busy));
      check($sformatf("v%0d_rd", v), 32'(rdm), 32'(vt[v].exp_rd));
      check($sformatf("v%0d_lat", v), 32'(first), 32'(vt[v].exp_lat));
      check($sformatf("v%0d_grant", v), 32'(gbad), 0);
      check($sformatf("v%0d_data", v), 32'(rx_diff()), 0);
    end

    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < NP; i++) q[i].delete();
    build_pkt(0, 0, 1'b0);
    push_pkt(0);
    build_pkt(1, 0, 1'b0);
    push_pkt(1);
    build_pkt(2, 0, 1'b0);
    push_pkt(2);
    build_pkt(0, 0, 1'b0);
    push_pkt(0);
    tick();
    tick();
    clr_rx();
    rel = cyc;
    reset = 1'b0;
    for (int t = 0; t < 24; t++) tick();
    check("rr_count", 32'(rx.size()), 8);
    if (rx.size() >= 8) begin
      check("rr_g0", 32'(rxg[0]), 0);
      check("rr_g1", 32'(rxg[2]), 1);
      check("rr_g2", 32'(rxg[4]), 2);
      check("rr_g3", 32'(rxg[6]), 0);
      check("rr_lat", 32'(rxc[0] - rel), 1);
      check("rr_gap1", 32'(rxc[2] - rxc[1]), 3);
      check("rr_gap2", 32'(rxc[4] - rxc[3]), 3);
      check("rr_gap3", 32'(rxc[6] - rxc[5]), 3);
    end

    do_reset();
    build_pkt(0, 6, 1'b0);
    push_pkt(0);
    wait_rx(3, 10);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_valid", 32'(s_valid), 1);
      check("bp_data", 32'(s_data), 32'(pkt[3]));
      check("bp_rd", 32'(s_rd), 0);
      check("bp_soft", 32'(s_soft), 0);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 20; t++) tick();
    check("bp_pkt", 32'(rx_diff()), 0);

    do_reset();
    build_pkt(2, 4, 1'b0);
    push_pkt(2);
    wait_rx(1, 10);
    out_ready = 1'b0;
    build_pkt(1, 0, 1'b0);
    push_pkt(1);
    build_pkt(0, 0, 1'b0);
    push_pkt(0);
    soft_acc = '0;
    stl = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (s_valid && !s_ready) stl++;
      if (k < 30) soft_acc |= s_soft;
    end
    check("wd_stalls", 32'(stl), 30);
    check("wd_early", 32'(soft_acc), 0);
    check("wd_pulse", 32'(s_soft), 32'(3'b100));
    tick();
    check("wd_idle_busy", 32'(s_busy), 0);
    check("wd_idle_soft", 32'(s_soft), 0);
    check("wd_idle_valid", 32'(s_valid), 0);
    clr_rx();
    out_ready = 1'b1;
    wait_rx(1, 10);
    if (rxg.size() != 0) check("wd_next_grant", 32'(rxg[0]), 0);

    do_reset();
    build_pkt(0, 8, 1'b0);
    for (int i = 0; i < 3; i++) q[0].push_back(pkt[i]);
    drive_fifos();
    soft_acc = '0;
    for (int t = 0; t < 40; t++) begin
      tick();
      soft_acc |= s_soft;
    end
    check("ur_rx", 32'(rx.size()), 3);
    check("ur_soft", 32'(soft_acc), 0);
    check("ur_busy", 32'(s_busy), 1);
    check("ur_valid", 32'(s_valid), 0);
    for (int i = 3; i < pkt.size(); i++) q[0].push_back(pkt[i]);
    drive_fifos();
    for (int t = 0; t < 20; t++) tick();
    check("ur_pkt", 32'(rx_diff()), 0);

    do_reset();
    build_pkt(1, 5, 1'b0);
    push_pkt(1);
    wait_rx(2, 10);
    reset = 1'b1;
    tick();
    check("mr_rd", 32'(s_rd), 0);
    check("mr_soft", 32'(s_soft), 0);
    check("mr_left", 32'(q[1].size()), 5);
    tick();
    check("mr_busy", 32'(s_busy), 0);
    check("mr_valid", 32'(s_valid), 0);

`ifdef ROUTER_ARB_PARITY_CHK_EN
    do_reset();
    build_pkt(0, 3, 1'b1);
    push_pkt(0);
    np = 0;
    pt = -1;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (s_perr) begin
        np++;
        pt = s_cyc;
      end
    end
    check("par_bad_pulses", 32'(np), 1);
    if (rxc.size() != 0) check("par_bad_when", 32'(pt - rxc[rxc.size()-1]), 1);
    check("par_bad_fwd", 32'(rx_diff()), 0);
    do_reset();
    build_pkt(1, 5, 1'b0);
    push_pkt(1);
    np = 0;
    for (int t = 0; t < 15; t++) begin
      tick();
      if (s_perr) np++;
    end
    check("par_good_pulses", 32'(np), 0);
    check("par_good_fwd", 32'(rx_diff()), 0);
`endif

    do_reset();
    for (int i = 0; i < NP; i++) begin
      src[i].delete();
      expq[i].delete();
      for (int p = 0; p < 6; p++) begin
        build_pkt(i, $urandom_range(9, 0), 1'b0);
        foreach (pkt[j]) begin
          src[i].push_back(pkt[j]);
          expq[i].push_back(pkt[j]);
        end
      end
    end
    cur_left = 0;
    cur_port = 0;
    in_hdr = 1'b0;
    last_port = NP - 1;
    last_end = -100;
    lowrun = 0;
    prev_ne = '0;
    soft_acc = '0;
    perr_acc = 1'b0;
    for (int it = 0; it < 4000 && remaining() > 0; it++) begin
      for (int i = 0; i < NP; i++) begin
        if (src[i].size() != 0 && $urandom_range(1, 0) == 1)
          q[i].push_back(src[i].pop_front());
      end
      if (lowrun >= 8) out_ready = 1'b1;
      else out_ready = ($urandom_range(3, 0) != 0);
      lowrun = out_ready ? 0 : lowrun + 1;
      drive_fifos();
      ne = ~fifo_empty;
      tick();
      if (s_valid && cur_left == 0 && !in_hdr) begin
        in_hdr = 1'b1;
        exp_g = rr(prev_ne, last_port);
        check("rnd_rr", 32'(s_grant), 32'(exp_g));
        check("rnd_gap", 32'(s_cyc - last_end >= 3), 1);
      end
      if (s_valid && s_ready) begin
        if (cur_left == 0) begin
          cur_port = int'(s_grant);
          cur_left = int'(s_data[7:2]) + 2;
          in_hdr = 1'b0;
        end
        check("rnd_grant", 32'(s_grant), 32'(cur_port));
        check("rnd_rd", 32'(s_rd), 32'(3'b001 << s_grant));
        if (s_grant < 2'(NP) && expq[s_grant].size() != 0) begin
          exp_b = expq[s_grant].pop_front();
          check("rnd_data", 32'(s_data), 32'(exp_b));
        end else begin
          check("rnd_extra", 1, 0);
        end
        cur_left--;
        if (cur_left == 0) begin
          last_end = s_cyc;
          last_port = cur_port;
        end
      end else if (s_rd != 3'b000) begin
        check("rnd_rd_idle", 32'(s_rd), 0);
      end
      soft_acc |= s_soft;
      perr_acc |= s_perr;
      prev_ne = ne;
    end
    check("rnd_drained", 32'(remaining()), 0);
    check("rnd_soft", 32'(soft_acc), 0);
    check("rnd_perr", 32'(perr_acc), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
